// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   ALU_WIDTH             default operand/result width
//   ALU_ADD/SUB/AND/OR    CTRL operation encodings
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the datapath and the ALU.
//   A, B    operands (driven by master)
//   CTRL    operation select (driven by master)
//   R       registered result (driven by slave)
//   zero    registered R==0 flag
//   ovf     registered signed-overflow flag
//   branch  registered equality-branch flag
interface alu_if import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       CTRL;
    logic [WIDTH-1:0] R;
    logic             zero;
    logic             ovf;
    logic             branch;

    modport master (
        output A, B, CTRL,
        input  R, zero, ovf, branch
    );

    modport slave (
        input  A, B, CTRL,
        output R, zero, ovf, branch
    );

endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder/subtractor.
//   a, b   operands
//   sub    0: a + b, 1: a - b (as a + ~b + 1)
//   sum    result modulo 2^WIDTH
//   ovf    signed (two's complement) overflow
module alu_addsub import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] cin_s;

    // Invert B and inject a carry-in of one for subtraction
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
            cin_s   = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            b_eff_s = b;
            cin_s   = {WIDTH{1'b0}};
        end
    end

    // Sum and overflow: overflow when both addends share a sign the sum lacks
    always_comb begin
        sum = a + b_eff_s + cin_s;
        ovf = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU for the execute stage, one-cycle latency.
//   clk    rising-edge clock
//   reset  synchronous active-high reset (R=0, zero=1, ovf=0, branch=0)
//   bus    alu_if.slave: A, B, CTRL in; R, zero, ovf, branch out (all registered)
module alu import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] sum_s;
    logic             add_ovf_s;
    logic             sub_s;
    logic [WIDTH-1:0] result_s;
    logic             ovf_s;
    logic             zero_s;
    logic             branch_s;

    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             ovf_r;
    logic             branch_r;

    assign sub_s = (bus.CTRL == ALU_SUB);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (bus.A),
        .b   (bus.B),
        .sub (sub_s),
        .sum (sum_s),
        .ovf (add_ovf_s)
    );

    // Result mux and flag generation for the next registered state
    always_comb begin
        result_s = {WIDTH{1'b0}};
        ovf_s    = 1'b0;
        case (bus.CTRL)
            ALU_ADD, ALU_SUB: begin
                result_s = sum_s;
                ovf_s    = add_ovf_s;
            end
            ALU_AND: begin
                result_s = bus.A & bus.B;
                ovf_s    = 1'b0;
            end
            ALU_OR: begin
                result_s = bus.A | bus.B;
                ovf_s    = 1'b0;
            end
            default: begin
                result_s = {WIDTH{1'b0}};
                ovf_s    = 1'b0;
            end
        endcase
        zero_s   = (result_s == {WIDTH{1'b0}});
        // Branch uses operand equality directly, so it is blind to overflow
        branch_s = sub_s && (bus.A == bus.B);
    end

    // Output registers; reset wins over the cycle's operation
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            ovf_r    <= 1'b0;
            branch_r <= 1'b0;
        end else begin
            result_r <= result_s;
            zero_r   <= zero_s;
            ovf_r    <= ovf_s;
            branch_r <= branch_s;
        end
    end

    assign bus.R      = result_r;
    assign bus.zero   = zero_r;
    assign bus.ovf    = ovf_r;
    assign bus.branch = branch_r;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random self-checking bench for alu.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [31:0] r,
                              input logic z, input logic o, input logic br);
        check({tag, ".R"},      bus.R, r);
        check({tag, ".zero"},   {31'd0, bus.zero}, {31'd0, z});
        check({tag, ".ovf"},    {31'd0, bus.ovf}, {31'd0, o});
        check({tag, ".branch"}, {31'd0, bus.branch}, {31'd0, br});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
        bus.A    = a;
        bus.B    = b;
        bus.CTRL = c;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
        drive(a, b, c);
        @(posedge clk);
        #1;
    endtask

    // Reference model returns {branch, ovf, zero, R}; overflow from wide signed math
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] c);
        logic [31:0] r;
        logic        o;
        longint      s;
        o = 1'b0;
        case (c)
            2'b00: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b01: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        return {(c == 2'b01) && (a == b), o, (r == 32'd0), r};
    endfunction

    initial begin
        logic [34:0] exp_v;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rc;
        logic        rr;
        checks   = 0;
        failures = 0;

        // Reset held two cycles with live operands
        reset = 1'b1;
        drive(32'd5, 32'd7, ALU_ADD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_all("reset", 32'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        step(32'd5, 32'd7, ALU_ADD);
        expect_all("post_reset_add", 32'd12, 1'b0, 1'b0, 1'b0);

        // ADD overflow and wrap
        step(32'h7FFF_FFFF, 32'd1, ALU_ADD);
        expect_all("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step(32'hFFFF_FFFF, 32'd1, ALU_ADD);
        expect_all("add_wrap", 32'd0, 1'b1, 1'b0, 1'b0);

        // SUB and branch
        step(32'h1234_5678, 32'h1234_5678, ALU_SUB);
        expect_all("sub_eq", 32'd0, 1'b1, 1'b0, 1'b1);
        step(32'd3, 32'd5, ALU_SUB);
        expect_all("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        step(32'h8000_0000, 32'd1, ALU_SUB);
        expect_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        step(32'h8000_0000, 32'h8000_0000, ALU_SUB);
        expect_all("sub_min_eq", 32'd0, 1'b1, 1'b0, 1'b1);
        step(32'd0, 32'd1, ALU_SUB);
        expect_all("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Logic ops
        step(32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND);
        expect_all("and", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
        step(32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR);
        expect_all("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        step(32'hAAAA_AAAA, 32'h5555_5555, ALU_AND);
        expect_all("and_zero", 32'd0, 1'b1, 1'b0, 1'b0);
        step(32'h8000_0000, 32'h8000_0000, ALU_OR);
        expect_all("or_min", 32'h8000_0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back with latency: new inputs do not show before the edge
        step(32'd6, 32'd3, ALU_ADD);
        check("b2b_add.R", bus.R, 32'd9);
        drive(32'd6, 32'd3, ALU_SUB);
        #2;
        check("b2b_hold_sub.R", bus.R, 32'd9);
        @(posedge clk); #1;
        check("b2b_sub.R", bus.R, 32'd3);
        drive(32'd6, 32'd3, ALU_AND);
        #2;
        check("b2b_hold_and.R", bus.R, 32'd3);
        @(posedge clk); #1;
        check("b2b_and.R", bus.R, 32'd2);
        step(32'd6, 32'd3, ALU_OR);
        check("b2b_or.R", bus.R, 32'd7);

        // Reset mid-stream discards the operation
        reset = 1'b1;
        step(32'h7FFF_FFFF, 32'h7FFF_FFFF, ALU_ADD);
        expect_all("mid_reset", 32'd0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        // Random regression with occasional resets
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = (($urandom_range(0, 7)) == 0) ? ra : 32'($urandom);
            rc = 2'($urandom_range(0, 3));
            rr = (i == 300) || (i == 301) || (i == 777);
            reset = rr;
            if (rr) begin
                exp_v = {1'b0, 1'b0, 1'b1, 32'd0};
            end else begin
                exp_v = model(ra, rb, rc);
            end
            step(ra, rb, rc);
            expect_all($sformatf("rand%0d", i), exp_v[31:0], exp_v[32], exp_v[33], exp_v[34]);
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit registered integer ALU for the CPU datapath execute stage.
- Each rising clock edge it samples operands A and B and a 2-bit operation code CTRL, then registers the result R.
- It also registers three status flags: zero, signed overflow (ovf), and a branch-taken indication for equality compare (branch).
- All outputs are registered; nothing is combinational from input to output.

Parameters:
- WIDTH, 32, operand and result width in bits. All behaviour below is stated for 32; it must scale unchanged.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- A  input  32  operand A (two's complement where signed)
- B  input  32  operand B
- CTRL  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR
- R  output  32  registered result
- zero  output  1  registered; 1 when the registered R is all zeros
- ovf  output  1  registered signed-overflow flag
- branch  output  1  registered equality-branch flag

Behaviour:
- Latency: exactly 1 cycle. Inputs are sampled at posedge N; R and the flags are valid after posedge N and hold until posedge N+1. No handshake; a new operation is accepted every cycle.
- Reset: when reset=1 at a posedge, R=0, zero=1, ovf=0, branch=0, regardless of A, B and CTRL. Reset has priority over the operation.
- The reset value of zero is 1 because it is consistent with R=0.
- Reset asserted mid-stream discards that cycle's operation. The first operation after reset release is computed normally.
- ADD (00): R = (A + B) mod 2^32. ovf = 1 iff A[31]==B[31] and R[31]!=A[31].
- SUB (01): R = (A - B) mod 2^32, computed as A + ~B + 1. ovf = 1 iff A[31]!=B[31] and R[31]!=A[31].
- AND (10): R = A & B; ovf = 0.
- OR (11): R = A | B; ovf = 0.
- zero: 1 iff next R == 0, for every operation.
- branch: 1 iff CTRL==01 and A==B (SUB result zero); otherwise 0.
- branch ignores ovf. Example: SUB of 0x80000000 - 0x80000000 gives R=0, ovf=0, branch=1.
- Carry-out is not exposed.
- Wrap-around: ADD and SUB wrap modulo 2^32. Examples: 0xFFFFFFFF + 1 gives R=0, zero=1, ovf=0; 0 - 1 gives R=0xFFFFFFFF, ovf=0.
- CTRL is a fully decoded 2-bit field; there are no illegal codes.
- Unknown (X) inputs are not required to be handled beyond simulation propagation.

Decomposition:
- Shared package alu_pkg holds:
  - the CTRL encodings: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11
  - the WIDTH default
- Sub-module alu_addsub: combinational WIDTH-bit adder/subtractor.
  - Inputs: a, b, sub.
  - Outputs: sum and signed overflow.
  - Used by alu for both ADD and SUB.
- alu contains the logic ops, the result mux, zero/branch detection and the output registers.

Test Plan:
- Reset: hold reset=1 for 2 cycles with A=5, B=7, CTRL=00 -> R=0, zero=1, ovf=0, branch=0. After release, the next edge gives R=12, zero=0.
- ADD overflow and wrap:
  - 0x7FFFFFFF + 1 -> R=0x80000000, ovf=1, zero=0.
  - 0xFFFFFFFF + 0x00000001 -> R=0, zero=1, ovf=0, branch=0.
- SUB and branch:
  - A=B=0x12345678, CTRL=01 -> R=0, zero=1, branch=1.
  - Next cycle A=3, B=5 -> R=0xFFFFFFFE, zero=0, branch=0, ovf=0.
  - 0x80000000 - 1 -> R=0x7FFFFFFF, ovf=1.
- Logic ops:
  - AND 0xF0F0F0F0 & 0x0FF00FF0 -> R=0x00F000F0, ovf=0.
  - OR of the same operands -> R=0xFFF0FFF0.
  - AND 0xAAAAAAAA & 0x55555555 -> R=0, zero=1, branch=0.
- Back-to-back and latency: change CTRL every cycle (00, 01, 10, 11) with A=6, B=3 -> R sequence 9, 3, 2, 7, each appearing exactly one edge after its inputs.
- Random regression: 1000 cycles of random A, B, CTRL compared against a 1-cycle-delayed reference model of R, zero, ovf and branch. Assert reset mid-run at least once and check the reset values.
